// File: rtl/pong_pkg.sv
// pong_pkg: shared channel state encoding and sizing helpers for the paddle array
package pong_pkg;

    typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} ch_state_t;

    function automatic int calc_cuenta(input int clk_hz, input int move_hz);
        return clk_hz / move_hz;
    endfunction

    function automatic int calc_presc_w(input int cuenta);
        return (cuenta < 2) ? 1 : $clog2(cuenta);
    endfunction

    // Wide enough to hold the held-tick count up to and including ACCEL_TICKS.
    function automatic int calc_hold_w(input int accel_ticks);
        return $clog2(accel_ticks + 1);
    endfunction

    function automatic int calc_speed_w(input int max_speed);
        return $clog2(max_speed + 1);
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// paddle_channel: one paddle's direction FSM, speed ramp, saturating position and limit flag
module paddle_channel
    import pong_pkg::*;
#(
    parameter int POS_W       = 7,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 127,
    parameter int RESET_POS   = 64,
    parameter int MAX_SPEED   = 3,
    parameter int ACCEL_TICKS = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_pause,
    input  logic             i_recenter,
    input  logic             i_left,
    input  logic             i_right,
    output logic [POS_W-1:0] o_pos,
    output logic             o_at_limit
);

    localparam int HW = calc_hold_w(ACCEL_TICKS);
    localparam int SW = calc_speed_w(MAX_SPEED);
    localparam int AW = POS_W + 2;
    localparam logic [POS_W-1:0]     RST_POS = POS_W'(RESET_POS);
    localparam logic [POS_W-1:0]     P_MIN   = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0]     P_MAX   = POS_W'(POS_MAX);
    localparam logic signed [AW-1:0] A_MIN   = AW'(POS_MIN);
    localparam logic signed [AW-1:0] A_MAX   = AW'(POS_MAX);
    localparam logic [SW-1:0]        SPD_ONE = SW'(1);
    localparam logic [SW-1:0]        S_MAX   = SW'(MAX_SPEED);
    localparam logic [HW:0]          ACC     = (HW + 1)'(ACCEL_TICKS);
    localparam logic                 RST_LIM = (RESET_POS == POS_MIN) || (RESET_POS == POS_MAX);

    ch_state_t               r_state, w_state_nxt, w_req;
    logic [SW-1:0]           r_speed, w_speed_nxt, w_spd;
    logic [HW-1:0]           r_hold, w_hold_nxt;
    logic [POS_W-1:0]        r_pos, w_pos_nxt;
    logic                    r_at_limit, w_lim_nxt, w_run;
    logic [HW:0]             w_cnt;
    logic signed [AW-1:0]    w_base, w_step, w_sum, w_sat;

    // The held-tick count includes the tick that enters a direction, so the
    // speed steps up after every ACCEL_TICKS consecutive ticks in one direction.
    // A fresh direction always moves by 1.
    assign w_req  = (i_left == i_right) ? IDLE : (i_left ? MOVE_L : MOVE_R);
    assign w_run  = (w_req == r_state);
    assign w_cnt  = (w_run ? {1'b0, r_hold} : '0) + 1'b1;
    assign w_spd  = w_run ? r_speed : SPD_ONE;
    assign w_base = AW'(r_pos);
    assign w_step = AW'(w_spd);
    assign w_sum  = (w_req == MOVE_R) ? w_base + w_step : w_base - w_step;
    assign w_sat  = (w_sum > A_MAX) ? A_MAX : (w_sum < A_MIN) ? A_MIN : w_sum;
    assign w_lim_nxt = (w_pos_nxt == P_MIN) || (w_pos_nxt == P_MAX);

    // Next state, ramp and position, advanced only on unpaused tick edges
    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_hold_nxt  = r_hold;
        w_pos_nxt   = r_pos;
        if (i_tick && !i_pause) begin
            if (w_req == IDLE) begin
                w_state_nxt = IDLE;
                w_speed_nxt = SPD_ONE;
                w_hold_nxt  = '0;
            end else begin
                w_state_nxt = w_req;
                w_pos_nxt   = w_sat[POS_W-1:0];
                w_speed_nxt = (w_cnt != ACC) ? w_spd : (w_spd == S_MAX) ? S_MAX : w_spd + SPD_ONE;
                w_hold_nxt  = (w_cnt == ACC) ? '0 : w_cnt[HW-1:0];
            end
        end
    end

    // State register; reset and recenter both return the paddle to its home position
    always_ff @(posedge clk) begin
        if (!rst || i_recenter) begin
            r_state    <= IDLE;
            r_speed    <= SPD_ONE;
            r_hold     <= '0;
            r_pos      <= RST_POS;
            r_at_limit <= RST_LIM;
        end else begin
            r_state    <= w_state_nxt;
            r_speed    <= w_speed_nxt;
            r_hold     <= w_hold_nxt;
            r_pos      <= w_pos_nxt;
            r_at_limit <= w_lim_nxt;
        end
    end

    assign o_pos      = r_pos;
    assign o_at_limit = r_at_limit;

endmodule

// File: rtl/paddle_array_ctrl.sv
// paddle_array_ctrl: N paddles on a shared move-rate prescaler; PADDLE_AI_TRACK_EN adds target tracking
module paddle_array_ctrl
    import pong_pkg::*;
#(
    parameter int N_PLAYERS   = 2,
    parameter int POS_W       = 7,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 127,
    parameter int RESET_POS   = 64,
    parameter int CLK_HZ      = 10_000_000,
    parameter int MOVE_HZ     = 100,
    parameter int MAX_SPEED   = 3,
    parameter int ACCEL_TICKS = 8
`ifdef PADDLE_AI_TRACK_EN
    ,
    parameter int DEADBAND    = 2
`endif
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*N_PLAYERS-1:0]       btns,
    input  logic                         pause,
    input  logic                         recenter,
`ifdef PADDLE_AI_TRACK_EN
    input  logic [N_PLAYERS-1:0]         ai_en,
    input  logic [POS_W-1:0]             target,
`endif
    output logic [N_PLAYERS*POS_W-1:0]   position,
    output logic [N_PLAYERS-1:0]         at_limit,
    output logic                         tick
);

    localparam int CUENTA = calc_cuenta(CLK_HZ, MOVE_HZ);
    localparam int CW     = calc_presc_w(CUENTA);
    localparam logic [CW-1:0] C_LAST = CW'(CUENTA - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Prescaler: tick is high for the cycle after the count reaches its last value
    always_ff @(posedge clk) begin
        if (!rst || recenter) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (pause) begin
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
            r_tick <= (r_cnt == C_LAST);
        end
    end

    assign tick = r_tick;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_ch
        logic             w_left, w_right;
        logic [POS_W-1:0] w_pos;
`ifdef PADDLE_AI_TRACK_EN
        assign w_left  = ai_en[g] ? (int'(target) + DEADBAND < int'(w_pos)) : btns[2*g];
        assign w_right = ai_en[g] ? (int'(target) > int'(w_pos) + DEADBAND) : btns[2*g+1];
`else
        assign w_left  = btns[2*g];
        assign w_right = btns[2*g+1];
`endif
        paddle_channel #(
            .POS_W       (POS_W),
            .POS_MIN     (POS_MIN),
            .POS_MAX     (POS_MAX),
            .RESET_POS   (RESET_POS),
            .MAX_SPEED   (MAX_SPEED),
            .ACCEL_TICKS (ACCEL_TICKS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_tick     (r_tick),
            .i_pause    (pause),
            .i_recenter (recenter),
            .i_left     (w_left),
            .i_right    (w_right),
            .o_pos      (w_pos),
            .o_at_limit (at_limit[g])
        );
        assign position[g*POS_W +: POS_W] = w_pos;
    end

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// tb_paddle_array_ctrl: directed and random stimulus against a behavioural paddle model
module tb_paddle_array_ctrl;

    localparam int N    = 2;
    localparam int PW   = 7;
    localparam int CU   = 10;
    localparam int MAXS = 3;
    localparam int ACC  = 2;
    localparam int RP   = 64;
    localparam int PMAX = 127;

    logic          clk = 0;
    logic          rst = 0;
    logic          pause = 0;
    logic          recenter = 0;
    logic [3:0]    btns = '0;
    logic [13:0]   position;
    logic [1:0]    at_limit;
    logic          tick;

    int n_chk = 0;
    int n_fail = 0;
    int m_pos [N];
    int m_dir [N];
    int m_run [N];
    int m_cnt = 0;
    bit m_tick = 0;
    int m_tk = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    paddle_array_ctrl #(
        .N_PLAYERS   (N),
        .POS_W       (PW),
        .POS_MIN     (0),
        .POS_MAX     (PMAX),
        .RESET_POS   (RP),
        .CLK_HZ      (100),
        .MOVE_HZ     (10),
        .MAX_SPEED   (MAXS),
        .ACCEL_TICKS (ACC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btns     (btns),
        .pause    (pause),
        .recenter (recenter),
        .position (position),
        .at_limit (at_limit),
        .tick     (tick)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: speed on the n-th consecutive held tick is 1 + (n-1)/ACC, capped.
    always @(posedge clk) begin
        if (!rst || recenter) begin
            for (int p = 0; p < N; p++) begin
                m_pos[p] = RP;
                m_dir[p] = 0;
                m_run[p] = 0;
            end
            m_cnt  = 0;
            m_tick = 0;
        end else if (pause) begin
            m_tick = 0;
        end else begin
            if (m_tick) begin
                m_tk++;
                for (int p = 0; p < N; p++) begin
                    int req;
                    int spd;
                    req = (btns[2*p] == btns[2*p+1]) ? 0 : (btns[2*p] ? -1 : 1);
                    if (req == 0) begin
                        m_dir[p] = 0;
                        m_run[p] = 0;
                    end else begin
                        m_run[p] = (req == m_dir[p]) ? m_run[p] + 1 : 1;
                        m_dir[p] = req;
                        spd = 1 + (m_run[p] - 1) / ACC;
                        if (spd > MAXS) spd = MAXS;
                        m_pos[p] = m_pos[p] + req * spd;
                        if (m_pos[p] > PMAX) m_pos[p] = PMAX;
                        if (m_pos[p] < 0) m_pos[p] = 0;
                    end
                end
            end
            m_tick = (m_cnt == CU - 1);
            m_cnt  = (m_cnt + 1) % CU;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < N; p++) begin
                check($sformatf("pos%0d", p), 32'(position[p*PW +: PW]), m_pos[p]);
                check($sformatf("lim%0d", p), 32'(at_limit[p]), 32'(m_pos[p] == 0 || m_pos[p] == PMAX));
            end
            check("tick", 32'(tick), 32'(m_tick));
        end
    end

    task automatic lit(input int p, input int exp);
        check($sformatf("lit_pos%0d", p), 32'(position[p*PW +: PW]), exp);
    endtask

    task automatic wait_move(input int k);
        for (int j = 0; j < k; j++) begin
            int s;
            int c;
            s = m_tk;
            c = 0;
            while (m_tk == s && c < 40) begin
                @(negedge clk);
                c++;
            end
            check("move_wait", 32'(m_tk != s), 1);
        end
    endtask

    task automatic pulse_recenter();
        recenter = 1;
        @(negedge clk);
        recenter = 0;
    endtask

    initial begin
        int t1;
        int t2;
        int ramp [6];
        t1 = 0;
        t2 = 0;
        ramp = '{65, 66, 68, 70, 73, 76};
        repeat (3) @(negedge clk);
        lit(0, 64);
        lit(1, 64);
        check("rst_lim", 32'(at_limit), 0);
        check("rst_tick", 32'(tick), 0);
        chk_en = 1;
        rst = 1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (tick) begin
                if (t1 == 0) t1 = i;
                else if (t2 == 0) t2 = i;
            end
        end
        check("tick_first", t1, 10);
        check("tick_period", t2 - t1, 10);

        btns = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            wait_move(1);
            lit(0, ramp[i]);
            lit(1, 64);
        end

        btns = 4'b0000;
        pulse_recenter();
        lit(0, 64);
        btns = 4'b0010; wait_move(1); lit(0, 65);
        btns = 4'b0000; wait_move(1); lit(0, 65);
        btns = 4'b0010; wait_move(1); lit(0, 66);
        btns = 4'b0000; wait_move(1); lit(0, 66);
        btns = 4'b0110;
        wait_move(22);
        lit(0, 126);
        lit(1, 4);
        wait_move(1);
        lit(0, 127);
        lit(1, 1);
        check("lim_p0", 32'(at_limit), 32'b01);
        wait_move(2);
        lit(0, 127);
        lit(1, 0);
        check("lim_both", 32'(at_limit), 32'b11);

        btns = 4'b0000;
        pulse_recenter();
        check("recenter_lim", 32'(at_limit), 0);
        btns = 4'b0100; wait_move(1); lit(1, 63);
        wait_move(1); lit(1, 62);
        btns = 4'b1000; wait_move(1); lit(1, 63);
        wait_move(1); lit(1, 64);
        btns = 4'b1100; wait_move(1); lit(1, 64);
        btns = 4'b0100; wait_move(1); lit(1, 63);
        lit(0, 64);

        btns = 4'b0000;
        pulse_recenter();
        btns = 4'b0010;
        wait_move(3);
        lit(0, 68);
        pause = 1;
        repeat (30) @(negedge clk);
        lit(0, 68);
        check("pause_tick", 32'(tick), 0);
        pause = 0;
        wait_move(1); lit(0, 70);
        wait_move(1); lit(0, 73);

        pause = 1;
        @(negedge clk);
        pulse_recenter();
        lit(0, 64);
        lit(1, 64);
        pause = 0;

        wait_move(4);
        lit(0, 70);
        rst = 0;
        @(negedge clk);
        lit(0, 64);
        lit(1, 64);
        rst = 1;
        wait_move(1); lit(0, 65);
        wait_move(1); lit(0, 66);
        wait_move(1); lit(0, 68);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom % 20 == 0) btns = 4'($urandom);
            pause    = ($urandom % 16 == 0);
            recenter = ($urandom % 97 == 0);
            rst      = !($urandom % 151 == 0);
        end
        @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_array_ctrl.md
Name: paddle_array_ctrl

Overview:
- Next-generation paddle controller for the Pong core: N independent paddles driven by one shared move-rate prescaler.
- Adds per-paddle speed ramp (acceleration while held), saturating limits, pause and recenter.
- Sits between the debounced button inputs and the renderer/collision logic; positions are registered outputs.

Parameters:
- N_PLAYERS, 2, number of paddles.
- POS_W, 7, position width in bits.
- POS_MIN, 0, lowest legal position.
- POS_MAX, 127, highest legal position; requires POS_MIN < POS_MAX < 2^POS_W.
- RESET_POS, 64, position after reset or recenter.
- CLK_HZ, 10_000_000, clock frequency.
- MOVE_HZ, 100, move-tick rate; CUENTA = CLK_HZ/MOVE_HZ, which must be at least 2.
- MAX_SPEED, 3, maximum step per tick (at least 1).
- ACCEL_TICKS, 8, number of consecutive held ticks per speed increment.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- btns  in  2*N_PLAYERS  bit 2i = left (decrease), bit 2i+1 = right (increase) for paddle i.
- pause  in  1  freezes all paddles.
- recenter  in  1  synchronous recenter request.
- position  out  N_PLAYERS*POS_W  paddle i occupies bits [i*POS_W +: POS_W].
- at_limit  out  N_PLAYERS  paddle i is at POS_MIN or POS_MAX.
- tick  out  1  one-cycle move strobe.

Behaviour:
- Reset (rst=0 at a clk edge): every position = RESET_POS, prescaler = 0, every state = IDLE, speed = 1, hold count = 0, tick = 0, at_limit = 0 (unless RESET_POS is at a limit). Reset has priority over everything and aborts any ramp in progress.
- Prescaler: counts 0..CUENTA-1 and wraps. The tick register is 1 during the cycle after the count reaches CUENTA-1, so tick period = CUENTA cycles.
- While pause=1: prescaler and all channel state are held, tick = 0, positions are unchanged.
- recenter=1 (when not in reset): on the next edge all positions = RESET_POS, states = IDLE, speed = 1, prescaler = 0. Recenter takes priority over pause and tick.
- Channel FSM, evaluated only on tick edges with buttons sampled on that edge:
  - Exactly one of left/right must be asserted for a move. Both or neither asserted -> IDLE, speed = 1, hold = 0, no move.
  - IDLE -> MOVE_L or MOVE_R on left-only or right-only.
  - Same direction held: hold increments; when hold reaches ACCEL_TICKS-1, speed = min(speed+1, MAX_SPEED) and hold = 0.
  - Direction reversal: switch state, speed = 1, hold = 0.
  - Moves take effect on the same tick edge as the state transition, using the speed value before any update on that edge.
- Arithmetic: signed, POS_W+2 bits wide, next = pos ± speed, saturated to [POS_MIN, POS_MAX]. No wrap-around is allowed.
- at_limit is registered and reflects the current position.
- Paddles are fully independent apart from the shared tick, pause and recenter.

Optional Feature:
- Macro: PADDLE_AI_TRACK_EN.
- Defined: adds ports ai_en (input, N_PLAYERS), target (input, POS_W) and parameter DEADBAND (default 2).
  - When ai_en[i]=1, paddle i's buttons are ignored and replaced by synthesized requests: left when target + DEADBAND < pos, right when target > pos + DEADBAND, otherwise neither.
  - Synthesized requests then go through the same FSM, ramp and saturation.
- Undefined: these ports and the parameter are absent; behaviour is buttons only.

Decomposition:
- Package pong_pkg:
  - channel state encoding: IDLE, MOVE_L, MOVE_R.
  - function computing CUENTA and the prescaler width as $clog2(CUENTA).
  - function computing the hold-count width.
- Sub-module paddle_channel, one instance per player in a generate loop.
  - Contains the FSM, speed ramp, saturation and at_limit logic.
  - Inputs: tick, pause, recenter, left, right.
- Top level contains the prescaler, the optional AI request mux and the output packing.

Test Plan (bench: CLK_HZ=100, MOVE_HZ=10 -> CUENTA=10; MAX_SPEED=3; ACCEL_TICKS=2; N_PLAYERS=2):
- Release reset -> both positions 64, at_limit=00; tick pulses every 10 cycles.
- P0 right held for 6 ticks -> P0 position 65, 66, 68, 70, 73, 76 (speed 1, 1, 2, 2, 3, 3); P1 stays 64.
- P0 at 126 with speed 3, right held -> next tick P0 = 127 and at_limit[0]=1; further ticks hold at 127, with no wrap to 0.
- P1 left at speed 2, then right asserted at the next tick -> that move is +1 and speed restarts at 1; both buttons on a later tick -> no move, state IDLE.
- pause=1 for 30 cycles while right held -> no tick, positions frozen; after release the ramp resumes from its held speed.
- recenter pulse while pause=1 -> both positions 64 on the next edge. rst=0 mid-ramp -> 64 and speed 1.
